// File: rtl/fnd_seq_pkg.sv
// Shared definitions for the fnd_seq datapath.
//   ser_state_t : serializer FSM state encoding (IDLE, SHIFT, DONE)
//   cnt_width() : counter width helper, $clog2(n) with a floor of 1 bit
package fnd_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } ser_state_t;

  // Width of a counter that must hold the values 0..n-1.
  localparam int unsigned MIN_CNT_W = 1;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 2) ? MIN_CNT_W : $clog2(n);
  endfunction

endpackage

// File: rtl/bit_tick_gen.sv
// DIV-cycle tick generator.
//   clk      : system clock, rising edge
//   reset_n  : asynchronous active-low reset
//   i_clr    : synchronous clear of the tick counter (wins over i_en)
//   i_en     : count enable
//   o_tick   : high in the last cycle of each DIV-cycle period while enabled
// Counter runs 0..DIV-1 and returns to 0 only by the wrap clear, never by
// overflow.
module bit_tick_gen
  import fnd_seq_pkg::*;
#(
  parameter int unsigned DIV   = 1,
  parameter int unsigned CNT_W = cnt_width(DIV)
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tick
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_wrap;

  assign w_wrap = i_en && (r_cnt == LAST);
  assign o_tick = w_wrap;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (i_clr || w_wrap) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/seq_serializer.sv
// Parallel-to-serial transmitter feeding the serial-capture flops.
//   clk         : system clock, rising edge
//   reset_n     : asynchronous active-low reset; aborts any word in flight
//   start       : load request (sampled with par_in)
//   par_in      : WIDTH-bit word to send
//   busy        : high while a word is in flight, including the done cycle
//   data_out    : serial bit, 0 when enable is low
//   enable      : high while data_out carries a valid bit
//   done        : one-cycle pulse after the last bit
//   o_dbg_state : internal FSM state (one cycle ahead of the outputs)
//
// Handshake: start is a request without acknowledge. It is taken at a rising
// edge only while the FSM is IDLE; in SHIFT and DONE it is ignored and
// nothing is queued. par_in matters only at the accepting edge.
//
// All outputs are registered from the FSM state, so each output lags the
// internal state by one cycle: a start taken at edge k shows up on the pins
// from edge k+1, and the next start can be taken at edge k+2+WIDTH*DIV.
module seq_serializer
  import fnd_seq_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DIV       = 1,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] par_in,
  output logic             busy,
  output logic             data_out,
  output logic             enable,
  output logic             done,
  output ser_state_t       o_dbg_state
);

  localparam int unsigned      BIT_W    = cnt_width(WIDTH);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WIDTH - 1);

  ser_state_t       r_state;
  ser_state_t       w_state_nxt;
  logic [WIDTH-1:0] r_shift;
  logic [BIT_W-1:0] r_bit_cnt;
  logic             r_busy;
  logic             r_data_out;
  logic             r_enable;
  logic             r_done;
  logic             w_load;
  logic             w_in_shift;
  logic             w_tick;
  logic             w_head;

  assign w_in_shift = (r_state == SHIFT);
  assign w_head     = MSB_FIRST ? r_shift[WIDTH-1] : r_shift[0];

  bit_tick_gen #(
    .DIV (DIV)
  ) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .i_clr   (w_load),
    .i_en    (w_in_shift),
    .o_tick  (w_tick)
  );

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_load      = 1'b1;
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (w_tick && (r_bit_cnt == LAST_BIT)) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Shift register and bit counter. The bit counter holds at its last value
  // after the final bit and is cleared by the next load.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
    end else if (w_load) begin
      r_shift   <= par_in;
      r_bit_cnt <= '0;
    end else if (w_in_shift && w_tick) begin
      if (MSB_FIRST) begin
        r_shift <= {r_shift[WIDTH-2:0], 1'b0};
      end else begin
        r_shift <= {1'b0, r_shift[WIDTH-1:1]};
      end
      if (r_bit_cnt != LAST_BIT) begin
        r_bit_cnt <= r_bit_cnt + 1'b1;
      end
    end
  end

  // Output registers, decoded from the current state only.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_busy     <= 1'b0;
      r_data_out <= 1'b0;
      r_enable   <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_busy     <= (r_state != IDLE);
      r_data_out <= w_in_shift && w_head;
      r_enable   <= w_in_shift;
      r_done     <= (r_state == DONE);
    end
  end

  assign busy        = r_busy;
  assign data_out    = r_data_out;
  assign enable      = r_enable;
  assign done        = r_done;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_seq_serializer.sv
// Directed bench for seq_serializer. Instance a: WIDTH=8, DIV=1, MSB first.
// Instance b: WIDTH=8, DIV=3, LSB first. Stimulus is driven and outputs are
// sampled on the falling edge.
module tb_seq_serializer;
  import fnd_seq_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT a ----------------
  logic       start_a = 1'b0;
  logic [7:0] par_a = 8'h00;
  logic       busy_a, data_a, en_a, done_a;
  ser_state_t st_a;

  seq_serializer #(.WIDTH(8), .DIV(1), .MSB_FIRST(1'b1)) u_dut_a (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start_a),
    .par_in      (par_a),
    .busy        (busy_a),
    .data_out    (data_a),
    .enable      (en_a),
    .done        (done_a),
    .o_dbg_state (st_a)
  );

  // ---------------- DUT b ----------------
  logic       start_b = 1'b0;
  logic [7:0] par_b = 8'h00;
  logic       busy_b, data_b, en_b, done_b;
  ser_state_t st_b;

  seq_serializer #(.WIDTH(8), .DIV(3), .MSB_FIRST(1'b0)) u_dut_b (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start_b),
    .par_in      (par_b),
    .busy        (busy_b),
    .data_out    (data_b),
    .enable      (en_b),
    .done        (done_b),
    .o_dbg_state (st_b)
  );

  // ---------------- scoreboard ----------------
  logic [0:0] exp_q[$];
  int n_checks = 0;
  int n_fail = 0;
  int done_cnt_a = 0;
  int done_cnt_b = 0;

  always @(negedge clk) begin
    if (done_a) done_cnt_a <= done_cnt_a + 1;
    if (done_b) done_cnt_b <= done_cnt_b + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_idle_a(input string tag);
    check({tag, "_busy"}, 32'(busy_a), 32'd0);
    check({tag, "_data"}, 32'(data_a), 32'd0);
    check({tag, "_en"},   32'(en_a),   32'd0);
    check({tag, "_done"}, 32'(done_a), 32'd0);
  endtask

  task automatic check_idle_b(input string tag);
    check({tag, "_busy"}, 32'(busy_b), 32'd0);
    check({tag, "_data"}, 32'(data_b), 32'd0);
    check({tag, "_en"},   32'(en_b),   32'd0);
    check({tag, "_done"}, 32'(done_b), 32'd0);
  endtask

  // ---------------- driver tasks ----------------
  // One word on instance a. With repulse set, start is raised with 8'hFF
  // during the SHIFT phase; it must be ignored.
  task automatic run_a(input logic [7:0] word, input bit repulse);
    int d0;
    @(negedge clk);
    start_a = 1'b1;
    par_a   = word;
    for (int i = 7; i >= 0; i--) exp_q.push_back(word[i]);
    @(negedge clk);               // start taken at edge k
    start_a = 1'b0;
    par_a   = ~word;              // mid-word changes must not matter
    d0 = done_cnt_a;
    check("a_state_shift", 32'(st_a), 32'(SHIFT));
    check("a_pre_en", 32'(en_a), 32'd0);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);             // after edge k+1+c
      check("a_en",   32'(en_a),   32'd1);
      check("a_busy", 32'(busy_a), 32'd1);
      check("a_done", 32'(done_a), 32'd0);
      check("a_bit",  32'(data_a), 32'(exp_q.pop_front()));
      if (repulse && c >= 1 && c <= 5) begin
        start_a = 1'b1;
        par_a   = 8'hFF;
      end else begin
        start_a = 1'b0;
      end
    end
    @(negedge clk);               // after edge k+9: done cycle
    check("a_done_pulse", 32'(done_a), 32'd1);
    check("a_done_en",    32'(en_a),   32'd0);
    check("a_done_busy",  32'(busy_a), 32'd1);
    check("a_done_data",  32'(data_a), 32'd0);
    @(negedge clk);               // after edge k+10
    check_idle_a("a_after");
    check("a_done_count", 32'(done_cnt_a - d0), 32'd1);
  endtask

  // One word on instance b (DIV=3, LSB first).
  task automatic run_b(input logic [7:0] word);
    int d0;
    @(negedge clk);
    start_b = 1'b1;
    par_b   = word;
    for (int i = 0; i < 8; i++) begin
      for (int r = 0; r < 3; r++) exp_q.push_back(word[i]);
    end
    @(negedge clk);
    start_b = 1'b0;
    par_b   = ~word;
    d0 = done_cnt_b;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      check("b_en",   32'(en_b),   32'd1);
      check("b_busy", 32'(busy_b), 32'd1);
      check("b_bit",  32'(data_b), 32'(exp_q.pop_front()));
    end
    @(negedge clk);
    check("b_done_pulse", 32'(done_b), 32'd1);
    check("b_done_en",    32'(en_b),   32'd0);
    @(negedge clk);
    check_idle_b("b_after");
    check("b_done_count", 32'(done_cnt_b - d0), 32'd1);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int d0;
    logic [7:0] w;

    // reset state
    #2;
    check_idle_a("rst_a");
    check_idle_b("rst_b");
    check("rst_state_a", 32'(st_a), 32'(IDLE));
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check_idle_a("rel_a");
    check("rel_state_b", 32'(st_b), 32'(IDLE));

    // basic word, MSB first, DIV=1
    run_a(8'hA5, 1'b0);

    // LSB first, DIV=3
    run_b(8'h01);
    run_b(8'hB6);

    // start re-pulsed mid-word is ignored, then a clean second word
    run_a(8'h00, 1'b1);
    run_a(8'h5A, 1'b0);

    // reset in the middle of 8'h3C
    @(negedge clk);
    start_a = 1'b1;
    par_a   = 8'h3C;
    @(negedge clk);
    start_a = 1'b0;
    d0 = done_cnt_a;
    repeat (5) @(negedge clk);    // send-order bit 4 = word bit 3
    check("rst_mid_bit4", 32'(data_a), 32'd1);
    check("rst_mid_en",   32'(en_a),   32'd1);
    #2 reset_n = 1'b0;
    #1;
    check_idle_a("rst_mid");
    check("rst_mid_state", 32'(st_a), 32'(IDLE));
    repeat (3) @(negedge clk);
    check_idle_a("rst_hold");
    reset_n = 1'b1;
    repeat (12) @(negedge clk);
    check_idle_a("rst_quiet");
    check("rst_no_done", 32'(done_cnt_a - d0), 32'd0);
    run_a(8'hC3, 1'b0);

    // start held high: one word every 10 cycles, 2-cycle enable gaps
    w = 8'h96;
    @(negedge clk);
    start_a = 1'b1;
    par_a   = w;
    @(negedge clk);               // first word taken at edge k
    d0 = done_cnt_a;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);             // after edge k+c
      if (((c - 1) % 10) < 8) begin
        check("cont_en",  32'(en_a),   32'd1);
        check("cont_bit", 32'(data_a), 32'(w[7 - ((c - 1) % 10)]));
      end else begin
        check("cont_gap_en",  32'(en_a),   32'd0);
        check("cont_gap_done", 32'(done_a), ((c - 1) % 10) == 8 ? 32'd1 : 32'd0);
      end
      if (c == 39) start_a = 1'b0;
    end
    check("cont_busy_end", 32'(busy_a), 32'd0);
    check("cont_done_count", 32'(done_cnt_a - d0), 32'd4);
    repeat (4) @(negedge clk);
    check_idle_a("cont_idle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
